// File: rtl/checkpoint_monitor_pkg.sv
// Shared types and code helpers for the checkpoint monitor.
package checkpoint_monitor_pkg;

  typedef enum logic [1:0] {
    BlkIdle    = 2'd0,
    BlkRunning = 2'd1,
    BlkPassed  = 2'd2,
    BlkFailed  = 2'd3
  } blk_state_e;

  localparam logic [7:0] StartPrefix  = 8'hA0;
  localparam logic [7:0] ResultPrefix = 8'hAB;
  localparam logic [7:0] TagBase      = 8'h40;
  localparam logic [7:0] PassMask     = 8'h01;

  // Block idx is identified by a single walking bit, starting at 8'h40.
  function automatic logic [7:0] block_tag(input int unsigned idx);
    return TagBase >> idx;
  endfunction

  function automatic logic [15:0] start_code_of(input int unsigned idx);
    return {StartPrefix, block_tag(idx)};
  endfunction

  function automatic logic [15:0] pass_code_of(input int unsigned idx);
    return {ResultPrefix, block_tag(idx) | PassMask};
  endfunction

  function automatic logic [15:0] fail_code_of(input int unsigned idx);
    return {ResultPrefix, block_tag(idx)};
  endfunction

endpackage

// File: rtl/checkpoint_monitor_if.sv
// Pad-side inputs and verdict outputs of the checkpoint monitor.
// master: the monitor itself; slave: whoever drives the pads and reads verdicts.
interface checkpoint_monitor_if #(
  parameter int unsigned N_BLOCKS = 2
);
  logic [15:0]           checkbits;
  logic                  clear;
  logic                  event_valid;
  logic [15:0]           event_code;
  logic [2*N_BLOCKS-1:0] block_state;
  logic                  done;
  logic                  pass;
  logic                  fail;
  logic                  timeout;
  logic [15:0]           fail_code;

  modport master (
    input  checkbits, clear,
    output event_valid, event_code, block_state, done, pass, fail, timeout, fail_code
  );

  modport slave (
    output checkbits, clear,
    input  event_valid, event_code, block_state, done, pass, fail, timeout, fail_code
  );
endinterface

// File: rtl/checkpoint_sync_filter.sv
// Synchronises the asynchronous pad code, waits for it to settle and emits one
// event pulse per newly settled value.
module checkpoint_sync_filter #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic [15:0] checkbits,
  output logic        event_valid,
  output logic [15:0] event_code
);

  localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

  logic [15:0] sync1_q, sync2_q, last_q;
  logic [7:0]  stable_q, stable_d;
  logic        valid_q;
  logic        decode;

  // Stability count restarts when a new value enters sync2; it reaches
  // StableMax once sync2 has held StableMax cycles past its first one.
  always_comb begin
    stable_d = stable_q;
    if (sync1_q != sync2_q) begin
      stable_d = 8'd0;
    end else if (stable_q != StableMax) begin
      stable_d = stable_q + 8'd1;
    end
    decode = (stable_q == StableMax) && (sync2_q != last_q);
  end

  // Synchroniser, stability counter and last-decoded register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      last_q   <= '0;
      valid_q  <= 1'b0;
    end else if (clear) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      last_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      sync1_q  <= checkbits;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      valid_q  <= decode;
      if (decode) begin
        last_q <= sync2_q;
      end
    end
  end

  assign event_valid = valid_q;
  assign event_code  = last_q;

endmodule

// File: rtl/checkpoint_monitor.sv
// Checkpoint monitor: decodes test-progress codes from pads, tracks one FSM per
// test block and raises sticky pass/fail/timeout verdicts.
// Build option: define CHECKPOINT_MONITOR_TIMEOUT_EN to include the idle timeout.
module checkpoint_monitor
  import checkpoint_monitor_pkg::*;
#(
  parameter int unsigned N_BLOCKS       = 2,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic                  clock,
  input logic                  reset,
  checkpoint_monitor_if.master bus
);

  if (N_BLOCKS == 0 || N_BLOCKS > 6) begin : gen_bad_n_blocks
    $error("N_BLOCKS must be 1..6");
  end
  if (STABLE_CYCLES == 0 || STABLE_CYCLES > 255) begin : gen_bad_stable
    $error("STABLE_CYCLES must be 1..255");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 32'h00FF_FFFF) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..2^24-1");
  end

  blk_state_e  state_q [N_BLOCKS];
  blk_state_e  state_d [N_BLOCKS];
  logic        done_q, done_d, pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
  logic [15:0] fail_code_q, fail_code_d;
  logic        accept, any_failed, all_passed, tmo_hit;

  checkpoint_sync_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_sync_filter (
    .clock      (clock),
    .reset      (reset),
    .clear      (bus.clear),
    .checkbits  (bus.checkbits),
    .event_valid(bus.event_valid),
    .event_code (bus.event_code)
  );

`ifdef CHECKPOINT_MONITOR_TIMEOUT_EN
  localparam logic [23:0] TimeoutMax = 24'(TIMEOUT_CYCLES);
  logic [23:0] tmo_cnt_q, tmo_cnt_d;

  // Idle counter: restarts on accepted block events, saturates at the limit.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (bus.clear) begin
      tmo_cnt_d = '0;
    end else if (accept) begin
      tmo_cnt_d = 24'd1;
    end else if (tmo_cnt_q != TimeoutMax) begin
      tmo_cnt_d = tmo_cnt_q + 24'd1;
    end
    tmo_hit = (tmo_cnt_d == TimeoutMax);
  end

  // Idle counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Block FSM next state and verdict flags; clear overrides everything.
  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    fail_code_d = fail_code_q;
    accept      = 1'b0;
    any_failed  = 1'b0;
    all_passed  = 1'b1;

    if (bus.event_valid && !done_q) begin
      for (int unsigned i = 0; i < N_BLOCKS; i++) begin
        if (bus.event_code == start_code_of(i)) begin
          accept     = 1'b1;
          state_d[i] = (state_q[i] == BlkIdle) ? BlkRunning : BlkFailed;
        end else if (bus.event_code == pass_code_of(i)) begin
          accept     = 1'b1;
          state_d[i] = (state_q[i] == BlkRunning) ? BlkPassed : BlkFailed;
        end else if (bus.event_code == fail_code_of(i)) begin
          // A fail code is an error in any state: either a real failure or a protocol one.
          accept     = 1'b1;
          state_d[i] = BlkFailed;
        end
      end
    end

    for (int unsigned i = 0; i < N_BLOCKS; i++) begin
      if (state_d[i] == BlkFailed) any_failed = 1'b1;
      if (state_d[i] != BlkPassed) all_passed = 1'b0;
    end

    // Only one verdict can ever be taken because each one also sets done.
    if (!done_q) begin
      if (any_failed) begin
        fail_d      = 1'b1;
        done_d      = 1'b1;
        fail_code_d = bus.event_code;
      end else if (all_passed) begin
        pass_d = 1'b1;
        done_d = 1'b1;
      end else if (tmo_hit && !accept) begin
        timeout_d = 1'b1;
        done_d    = 1'b1;
      end
    end

    if (bus.clear) begin
      for (int unsigned i = 0; i < N_BLOCKS; i++) state_d[i] = BlkIdle;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      timeout_d   = 1'b0;
      fail_code_d = '0;
    end
  end

  // Block states and sticky verdict registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= '{default: BlkIdle};
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      fail_code_q <= fail_code_d;
    end
  end

  // Pack per-block states onto the output bus.
  always_comb begin
    bus.block_state = '0;
    for (int unsigned i = 0; i < N_BLOCKS; i++) begin
      bus.block_state[2*i +: 2] = state_q[i];
    end
  end

  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.timeout   = timeout_q;
  assign bus.fail_code = fail_code_q;

endmodule

// File: doc/checkpoint_monitor.md
CHECKPOINT_MONITOR -- requirements
Module: checkpoint_monitor

Interface
REQ-001 Parameter N_BLOCKS, default 2: number of monitored test blocks (legal 1..6).
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive cycles a synchronised code must hold before it is decoded (legal 1..255).
REQ-003 Parameter TIMEOUT_CYCLES, default 100000: idle cycles allowed between accepted events (legal 1..2^24-1).
REQ-004 clock  input  1  single block clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 checkbits  input  16  asynchronous test-progress code from pads (mprj_io[31:16]).
REQ-007 clear  input  1  synchronous pulse; returns all state to reset values.
REQ-008 event_valid  output  1  one-cycle pulse per decoded code.
REQ-009 event_code  output  16  code decoded with the current event_valid; holds between pulses.
REQ-010 block_state  output  2*N_BLOCKS  per-block state, block i at [2i+1:2i].
REQ-011 done, pass, fail, timeout  output  1 each  sticky global verdict flags.
REQ-012 fail_code  output  16  code that set fail.

Function
REQ-013 Block i tag SHALL be 8'h40 >> i; start code = {8'hA0, tag}; fail code = {8'hAB, tag}; pass code = {8'hAB, tag | 8'h01}.
REQ-014 checkbits SHALL pass through a 2-flop synchroniser, then a stability counter; a value is decoded once, when it has held STABLE_CYCLES cycles and differs from the last decoded value.
REQ-015 Latency: a change that is stable from edge k SHALL raise event_valid in cycle k+2+STABLE_CYCLES; a glitch shorter than STABLE_CYCLES SHALL produce no event.
REQ-016 Per-block FSM states: IDLE=0, RUNNING=1, PASSED=2, FAILED=3.
REQ-017 IDLE + start -> RUNNING; RUNNING + pass -> PASSED; RUNNING + fail -> FAILED.
REQ-018 Start when not IDLE, or pass/fail when not RUNNING, SHALL set that block FAILED (protocol error).
REQ-019 Codes matching no block SHALL raise event_valid but change no state and not restart the timeout counter.
REQ-020 fail SHALL set when any block enters FAILED; fail_code captures the causing code; done sets simultaneously.
REQ-021 pass and done SHALL set when all N_BLOCKS blocks are PASSED.
REQ-022 Once done=1, further events SHALL still pulse event_valid but SHALL change no block state or flag.
REQ-023 Timeout counter SHALL restart on every accepted block event and saturate; on reaching TIMEOUT_CYCLES with done=0, timeout and done set; block states unchanged.
REQ-024 Block event and timeout in the same cycle: event wins, timeout not set.
REQ-025 clear and event in the same cycle: clear wins, event discarded (event_valid=0).
REQ-026 At most one verdict among pass/fail/timeout SHALL ever be 1.

Reset
REQ-027 reset SHALL asynchronously force all outputs to 0, all blocks IDLE, synchroniser/stability/last-decoded registers to 0, timeout counter to 0.
REQ-028 Reset mid-test SHALL discard progress; after release, the currently held checkbits value is decoded as a new event once stable (unless 16'h0000).
REQ-029 clear SHALL produce the same state as reset, one cycle later, synchronously.

Configuration
REQ-030 Macro CHECKPOINT_MONITOR_TIMEOUT_EN: defined -> timeout counter and REQ-023/024 present; undefined -> no counter logic, timeout tied 0, done set only by pass/fail.

Structure
REQ-031 Package checkpoint_monitor_pkg SHALL hold block-state enum, code prefixes 8'hA0/8'hAB, tag base 8'h40, pass-bit mask.
REQ-032 Sub-module checkpoint_sync_filter SHALL implement synchroniser, stability counter and change detect, outputting event_valid/event_code.

Verification
REQ-033 Drive A040, AB41, A020, AB21 each held 10 cycles -> block_state 2'b10 both, pass=1, done=1, fail=0.
REQ-034 Drive A040 then AB40 -> block0 FAILED, fail=1, fail_code=16'hAB40, pass=0.
REQ-035 Pulse checkbits to A020 for STABLE_CYCLES-1 cycles -> no event_valid, states unchanged.
REQ-036 Drive AB21 with block1 IDLE -> block1 FAILED, fail=1 (protocol error).
REQ-037 With TIMEOUT_EN, TIMEOUT_CYCLES=50, drive A040 then hold -> timeout=1, done=1 exactly 50 cycles after the event; without macro, timeout stays 0.
REQ-038 Assert reset while block0 RUNNING -> all outputs 0 immediately; after release with A040 held, event_valid after 2+STABLE_CYCLES cycles and block0 RUNNING.
